// File: rtl/cmd_sequencer_pkg.sv
// Shared definitions for the DDR3 command sequencer: state encoding,
// the NOP command pattern and the power-up levels of CKE/ODT.
package cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    // {RAS, CAS, WE} pin levels for a NOP (all deasserted, active-low pins)
    localparam logic [2:0] NOP_RCW = 3'b111;

    // DDR3 power-up requires CKE low; ODT starts off
    localparam logic RST_CKE = 1'b0;
    localparam logic RST_ODT = 1'b0;

endpackage

// File: rtl/cmd_wait_cnt.sv
// Loadable down-counter timing the NOP gap after a command.
// The terminal flag is raised while the count equals 1, which is the last
// NOP cycle before the sequencer moves on.
module cmd_wait_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_term
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_term = (r_count == WIDTH'(1));

endmodule

// File: rtl/cmd_sequencer.sv
// DDR3 command sequencer: takes one command per handshake, expands it into
// a two-slot (command, NOP) output vector per clk_div cycle and pads each
// command with a programmable number of NOP cycles.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int ADDRESS_NUMBER = 15,
    parameter int NOP_WIDTH      = 10
) (
    input  logic                        clk_div,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        tri_idle,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDRESS_NUMBER-1:0]   cmd_addr,
    input  logic [2:0]                  cmd_ba,
    input  logic                        cmd_ras,
    input  logic                        cmd_cas,
    input  logic                        cmd_we,
    input  logic                        cmd_cke,
    input  logic                        cmd_odt,
    input  logic [NOP_WIDTH-1:0]        cmd_nop,
    input  logic                        cmd_last,
    output logic [2*ADDRESS_NUMBER-1:0] out_a,
    output logic [5:0]                  out_ba,
    output logic [1:0]                  out_we,
    output logic [1:0]                  out_ras,
    output logic [1:0]                  out_cas,
    output logic [1:0]                  out_cke,
    output logic [1:0]                  out_odt,
    output logic                        out_tri,
    output logic                        busy,
    output logic                        seq_done,
    output logic                        underrun
);

    seq_state_t                  r_state;
    seq_state_t                  w_next_state;
    logic                        r_rst_seen;
    logic                        r_last;
    logic                        w_accept;
    logic                        w_run_go;
    logic                        w_load;
    logic                        w_cnt_term;

    logic [2*ADDRESS_NUMBER-1:0] r_a;
    logic [5:0]                  r_ba;
    logic [1:0]                  r_we;
    logic [1:0]                  r_ras;
    logic [1:0]                  r_cas;
    logic [1:0]                  r_cke;
    logic [1:0]                  r_odt;
    logic                        r_tri;
    logic                        r_busy;
    logic                        r_seq_done;
    logic                        r_underrun;

    // Blocks run on the first edge after reset release so a run pulse
    // coinciding with rst_n rising is ignored.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_seen <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            r_rst_seen <= 1'b1;
        end
    end

    // State register plus the last-command flag captured on accept.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_last <= cmd_last;
            end
        end
    end

    // Next-state decode, accept and counter-load strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_run_go     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run && r_rst_seen) begin
                    w_run_go     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_nop != '0) begin
                        w_load       = 1'b1;
                        w_next_state = ST_WAIT;
                    end else if (cmd_last) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (w_cnt_term) begin
                    w_next_state = r_last ? ST_IDLE : ST_ISSUE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == ST_ISSUE);

    cmd_wait_cnt #(
        .WIDTH (NOP_WIDTH)
    ) u_wait_cnt (
        .i_clk      (clk_div),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_load_val (cmd_nop),
        .i_dec      (r_state == ST_WAIT),
        .o_term     (w_cnt_term)
    );

    // Registered command/address vectors and status outputs. Address, bank,
    // CKE and ODT only change on an accepted command to minimise toggling.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_ba       <= '0;
            r_ras      <= {2{NOP_RCW[2]}};
            r_cas      <= {2{NOP_RCW[1]}};
            r_we       <= {2{NOP_RCW[0]}};
            r_cke      <= {2{RST_CKE}};
            r_odt      <= {2{RST_ODT}};
            r_tri      <= 1'b1;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= {cmd_addr, cmd_addr};
                r_ba  <= {cmd_ba, cmd_ba};
                r_ras <= {NOP_RCW[2], cmd_ras};
                r_cas <= {NOP_RCW[1], cmd_cas};
                r_we  <= {NOP_RCW[0], cmd_we};
                r_cke <= {2{cmd_cke}};
                r_odt <= {2{cmd_odt}};
            end else begin
                r_ras <= {2{NOP_RCW[2]}};
                r_cas <= {2{NOP_RCW[1]}};
                r_we  <= {2{NOP_RCW[0]}};
            end
            r_tri      <= (r_state == ST_IDLE) && !w_run_go && tri_idle;
            r_busy     <= (w_next_state != ST_IDLE);
            r_seq_done <= (r_state != ST_IDLE) && (w_next_state == ST_IDLE);
            if (w_run_go) begin
                r_underrun <= 1'b0;
            end else if ((r_state == ST_ISSUE) && !cmd_valid) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign out_a    = r_a;
    assign out_ba   = r_ba;
    assign out_ras  = r_ras;
    assign out_cas  = r_cas;
    assign out_we   = r_we;
    assign out_cke  = r_cke;
    assign out_odt  = r_odt;
    assign out_tri  = r_tri;
    assign busy     = r_busy;
    assign seq_done = r_seq_done;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer. Inputs change 1 time unit after the
// rising edge of clk_div; outputs are compared at that same point, well
// away from the next active edge.
module tb_cmd_sequencer;

    localparam int AN = 15;
    localparam int NW = 10;

    logic            clk_div = 1'b0;
    logic            rst_n;
    logic            run;
    logic            tri_idle;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AN-1:0]   cmd_addr;
    logic [2:0]      cmd_ba;
    logic            cmd_ras, cmd_cas, cmd_we, cmd_cke, cmd_odt;
    logic [NW-1:0]   cmd_nop;
    logic            cmd_last;
    logic [2*AN-1:0] out_a;
    logic [5:0]      out_ba;
    logic [1:0]      out_we, out_ras, out_cas, out_cke, out_odt;
    logic            out_tri, busy, seq_done, underrun;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_sequencer #(
        .ADDRESS_NUMBER (AN),
        .NOP_WIDTH      (NW)
    ) dut (
        .clk_div   (clk_div),
        .rst_n     (rst_n),
        .run       (run),
        .tri_idle  (tri_idle),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_ba    (cmd_ba),
        .cmd_ras   (cmd_ras),
        .cmd_cas   (cmd_cas),
        .cmd_we    (cmd_we),
        .cmd_cke   (cmd_cke),
        .cmd_odt   (cmd_odt),
        .cmd_nop   (cmd_nop),
        .cmd_last  (cmd_last),
        .out_a     (out_a),
        .out_ba    (out_ba),
        .out_we    (out_we),
        .out_ras   (out_ras),
        .out_cas   (out_cas),
        .out_cke   (out_cke),
        .out_odt   (out_odt),
        .out_tri   (out_tri),
        .busy      (busy),
        .seq_done  (seq_done),
        .underrun  (underrun)
    );

    always #5 clk_div = ~clk_div;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic drive_cmd(input logic [AN-1:0] a, input logic [2:0] ba,
                             input logic ras, input logic cas, input logic we,
                             input logic cke, input logic odt,
                             input logic [NW-1:0] nop, input logic last);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_ba    = ba;
        cmd_ras   = ras;
        cmd_cas   = cas;
        cmd_we    = we;
        cmd_cke   = cke;
        cmd_odt   = odt;
        cmd_nop   = nop;
        cmd_last  = last;
    endtask

    logic [2*AN-1:0] exp_a;

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        tri_idle  = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_ba    = '0;
        cmd_ras   = 1'b1;
        cmd_cas   = 1'b1;
        cmd_we    = 1'b1;
        cmd_cke   = 1'b0;
        cmd_odt   = 1'b0;
        cmd_nop   = '0;
        cmd_last  = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_ras",   32'(out_ras),   32'h3);
        check("rst_cas",   32'(out_cas),   32'h3);
        check("rst_we",    32'(out_we),    32'h3);
        check("rst_cke",   32'(out_cke),   32'h0);
        check("rst_odt",   32'(out_odt),   32'h0);
        check("rst_a",     32'(out_a),     32'h0);
        check("rst_tri",   32'(out_tri),   32'h1);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h0);

        // run together with reset release is ignored
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        run = 1'b0;
        check("run_at_release_busy", 32'(busy), 32'h0);
        tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_tri",  32'(out_tri), 32'h1);

        // ---------------- ACTIVATE then READ ----------------
        run = 1'b1;
        tick();
        run = 1'b0;
        check("run_busy",  32'(busy),      32'h1);
        check("run_tri",   32'(out_tri),   32'h0);
        check("run_ready", 32'(cmd_ready), 32'h1);
        drive_cmd(15'h1234, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
        tick();
        exp_a = {15'h1234, 15'h1234};
        check("act_ras", 32'(out_ras), 32'h2);
        check("act_cas", 32'(out_cas), 32'h3);
        check("act_we",  32'(out_we),  32'h3);
        check("act_a",   32'(out_a),   32'(exp_a));
        check("act_ba",  32'(out_ba),  32'h1b);
        check("act_cke", 32'(out_cke), 32'h3);
        check("act_ready", 32'(cmd_ready), 32'h1);
        drive_cmd(15'h0010, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        exp_a = {15'h0010, 15'h0010};
        check("rd_ras",  32'(out_ras),  32'h3);
        check("rd_cas",  32'(out_cas),  32'h2);
        check("rd_a",    32'(out_a),    32'(exp_a));
        check("rd_done", 32'(seq_done), 32'h1);
        check("rd_busy", 32'(busy),     32'h0);
        check("rd_tri",  32'(out_tri),  32'h0);
        tick();
        check("rd_done_pulse", 32'(seq_done), 32'h0);
        check("rd_tri_after",  32'(out_tri),  32'h1);
        check("rd_cke_idle",   32'(out_cke),  32'h3);
        check("rd_ras_idle",   32'(out_ras),  32'h3);
        check("rd_underrun",   32'(underrun), 32'h0);

        // ---------------- NOP spacing, run while busy, CKE hold ----------------
        run = 1'b1;
        tick();
        run = 1'b0;
        drive_cmd(15'h0aaa, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd3, 1'b0);
        tick();   // A issued
        check("sp_a_ras", 32'(out_ras), 32'h2);
        check("sp_a_odt", 32'(out_odt), 32'h3);
        drive_cmd(15'h0055, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sp_wait%0d_ready", i), 32'(cmd_ready), 32'h0);
            if (i > 0) begin
                check($sformatf("sp_wait%0d_ras", i), 32'(out_ras), 32'h3);
                check($sformatf("sp_wait%0d_cke", i), 32'(out_cke), 32'h3);
                check($sformatf("sp_wait%0d_ba",  i), 32'(out_ba),  32'h2d);
            end
            tick();
        end
        check("sp_issue_ready", 32'(cmd_ready), 32'h1);
        check("sp_issue_ras",   32'(out_ras),   32'h3);
        tick();   // B issued on cycle +4
        check("sp_b_cas",   32'(out_cas),   32'h2);
        check("sp_b_odt",   32'(out_odt),   32'h0);
        check("sp_b_ready", 32'(cmd_ready), 32'h0);
        cmd_valid = 1'b0;
        run = 1'b1;   // ignored while busy
        tick();
        run = 1'b0;
        check("busy_run_busy",  32'(busy),      32'h1);
        check("busy_run_ready", 32'(cmd_ready), 32'h0);
        check("busy_run_done",  32'(seq_done),  32'h0);
        tick();
        check("sp_b_done", 32'(seq_done), 32'h1);
        check("sp_b_idle", 32'(busy),     32'h0);
        check("sp_b_tri",  32'(out_tri),  32'h0);
        tick();
        check("sp_tri_after", 32'(out_tri), 32'h1);
        check("sp_cke_idle",  32'(out_cke), 32'h3);
        check("sp_underrun",  32'(underrun), 32'h0);

        // ---------------- underrun ----------------
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("ur1_flag",  32'(underrun),  32'h1);
        check("ur1_ras",   32'(out_ras),   32'h3);
        check("ur1_ready", 32'(cmd_ready), 32'h1);
        tick();
        check("ur2_flag",  32'(underrun),  32'h1);
        check("ur2_cas",   32'(out_cas),   32'h3);
        drive_cmd(15'h0100, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        check("ur_wr_we",   32'(out_we),   32'h2);
        check("ur_wr_cas",  32'(out_cas),  32'h2);
        check("ur_wr_flag", 32'(underrun), 32'h1);
        tick();
        check("ur_hold_idle", 32'(underrun), 32'h1);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("ur_clear", 32'(underrun), 32'h0);

        // ---------------- reset mid-WAIT ----------------
        drive_cmd(15'h7fff, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd5, 1'b0);
        tick();
        cmd_valid = 1'b0;
        check("mw_cke", 32'(out_cke), 32'h3);
        tick();
        check("mw_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ras",  32'(out_ras), 32'h3);
        check("arst_cke",  32'(out_cke), 32'h0);
        check("arst_odt",  32'(out_odt), 32'h0);
        check("arst_tri",  32'(out_tri), 32'h1);
        check("arst_a",    32'(out_a),   32'h0);
        check("arst_busy", 32'(busy),    32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy",  32'(busy),      32'h0);
        check("post_rst_ready", 32'(cmd_ready), 32'h0);
        check("post_rst_tri",   32'(out_tri),   32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
